// File: rtl/lcd_hex_writer.sv
// Hex-to-ASCII frame writer for a character LCD driver.
// Streams NUM_NIBBLES hex digits, MSB first, with an optional home command.
module lcd_hex_writer #(
  parameter int NUM_NIBBLES = 16,
  parameter bit HOME_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] value,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        lcd_ready,
  output logic [7:0]  lcd_char,
  output logic        lcd_write,
  output logic        lcd_home
);

  typedef enum logic [2:0] {
    IDLE,
    HOME_REQ,
    HOME_WAIT_LO,
    HOME_WAIT_HI,
    CHAR_REQ,
    CHAR_WAIT_LO,
    CHAR_WAIT_HI,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_NIBBLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [63:0] shadow_q;
  logic [3:0]  cnt_q;
  logic        load;
  logic        advance;
  logic [3:0]  nib_idx;
  logic [3:0]  nibble;
  logic [7:0]  code;
  logic        in_char;

  // State, shadow copy of the value and digit counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        shadow_q <= value;
        cnt_q    <= '0;
      end else if (advance) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  // Next state, strobes and status flags
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    advance   = 1'b0;
    lcd_write = 1'b0;
    lcd_home  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load    = 1'b1;
          state_d = HOME_FIRST ? HOME_REQ : CHAR_REQ;
        end
      end
      HOME_REQ: begin
        if (lcd_ready) begin
          lcd_home = 1'b1;
          state_d  = HOME_WAIT_LO;
        end
      end
      HOME_WAIT_LO: begin
        if (!lcd_ready) state_d = HOME_WAIT_HI;
      end
      HOME_WAIT_HI: begin
        if (lcd_ready) state_d = CHAR_REQ;
      end
      CHAR_REQ: begin
        if (lcd_ready) begin
          lcd_write = 1'b1;
          state_d   = CHAR_WAIT_LO;
        end
      end
      CHAR_WAIT_LO: begin
        if (!lcd_ready) state_d = CHAR_WAIT_HI;
      end
      CHAR_WAIT_HI: begin
        if (lcd_ready) begin
          advance = 1'b1;
          state_d = (cnt_q == LAST) ? DONE : CHAR_REQ;
        end
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit select and ASCII encode; held until the counter advances
  always_comb begin
    nib_idx = LAST - cnt_q;
    nibble  = shadow_q[{nib_idx, 2'b00} +: 4];
    in_char = (state_q == CHAR_REQ) ||
              (state_q == CHAR_WAIT_LO) ||
              (state_q == CHAR_WAIT_HI);
    code    = 8'h20;
    unique case (1'b1)
      (nibble <= 4'd9): code = 8'h30 + {4'h0, nibble};
      (nibble >= 4'hA): code = 8'h37 + {4'h0, nibble};
    endcase
    lcd_char = in_char ? code : 8'h20;
  end

endmodule

// File: doc/lcd_hex_writer.md
LCD_HEX_WRITER -- requirements
Module: lcd_hex_writer

Interface
REQ-001 Parameter NUM_NIBBLES, default 16, number of hex characters written per frame (1..16).
REQ-002 Parameter HOME_FIRST, default 1, when 1 each frame starts with a home command.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 value  input  64  data to display, sampled only on accepted start.
REQ-007 start  input  1  one-cycle request to display value.
REQ-008 busy  output  1  high from accepted start until frame complete.
REQ-009 done  output  1  one-cycle pulse when last character is acknowledged.
REQ-010 lcd_ready  input  1  LCD driver idle/ready flag.
REQ-011 lcd_char  output  8  ASCII character to LCD driver.
REQ-012 lcd_write  output  1  one-cycle write-character strobe to LCD driver.
REQ-013 lcd_home  output  1  one-cycle cursor-home strobe to LCD driver.

Function
REQ-014 States: IDLE, HOME_REQ, HOME_WAIT_LO, HOME_WAIT_HI, CHAR_REQ, CHAR_WAIT_LO, CHAR_WAIT_HI, DONE.
REQ-015 IDLE: start=1 latches value into a 64-bit shadow register, clears nibble counter, sets busy, goes to HOME_REQ if HOME_FIRST=1 else CHAR_REQ.
REQ-016 start while busy=1 is ignored; shadow register and counter unchanged.
REQ-017 HOME_REQ: lcd_home=1 for exactly one cycle, only in a cycle where lcd_ready=1; then HOME_WAIT_LO; stays in HOME_REQ with strobe low while lcd_ready=0.
REQ-018 *_WAIT_LO: wait until lcd_ready=0, then *_WAIT_HI; *_WAIT_HI: wait until lcd_ready=1.
REQ-019 HOME_WAIT_HI exit -> CHAR_REQ.
REQ-020 CHAR_REQ: lcd_write=1 for exactly one cycle when lcd_ready=1; then CHAR_WAIT_LO.
REQ-021 CHAR_WAIT_HI exit: counter increments; if counter reached NUM_NIBBLES-1 before increment -> DONE, else CHAR_REQ.
REQ-022 Nibble order MSB first: character k (0-based) encodes shadow[(NUM_NIBBLES-1-k)*4 +: 4].
REQ-023 Encoding: 0x0-0x9 -> 0x30-0x39; 0xA-0xF -> 0x41-0x46 (upper case).
REQ-024 lcd_char SHALL be valid in the CHAR_REQ strobe cycle and held stable through CHAR_WAIT_HI exit (driver samples nibbles late).
REQ-025 lcd_write and lcd_home never high in the same cycle; never high outside their REQ states.
REQ-026 DONE: done=1 one cycle, busy=0 in the same cycle, -> IDLE; start in DONE cycle ignored.
REQ-027 Per-character latency, lcd_ready constantly high except driver-driven drop: strobe cycle + wait states only; no extra idle cycles between characters beyond one CHAR_REQ cycle.
REQ-028 value changes after accepted start do not affect the frame in progress.

Reset
REQ-029 rst_n=0 at any rising edge: state IDLE, busy=0, done=0, lcd_write=0, lcd_home=0, lcd_char=0x20, counter=0, shadow=0.
REQ-030 Reset mid-frame aborts immediately; no further strobes; no done pulse.
REQ-031 First start after reset release is accepted on the first cycle with rst_n=1.

Verification
REQ-032 Driver model (ready drops 1 cycle after strobe, rises 40 cycles later); start with value=0x0123456789ABCDEF, HOME_FIRST=1 -> one home then chars "0123456789ABCDEF" in order, single done pulse, busy low afterwards.
REQ-033 lcd_ready held 0 for 500 cycles after start -> no strobes, busy=1; release -> home strobe next cycle with ready=1.
REQ-034 Second start and value change mid-frame -> ignored; output still matches first value; exactly 17 strobes total.
REQ-035 rst_n=0 after 5th character acknowledged -> next cycle all outputs at reset values; no done; new start with 0xFFFFFFFFFFFFFFFF -> 16 'F' (0x46).
REQ-036 NUM_NIBBLES=8, HOME_FIRST=0, value=0x00000000DEADBEEF -> no home; chars "DEADBEEF"; done after 8th acknowledge.
REQ-037 Checker throughout: lcd_char stable from write strobe until ready re-rises; lcd_write/lcd_home mutually exclusive and single-cycle.
